i2c_txn_arbiter: RTL and testbench

//   Shares one i2c_master among NREQ requesters. Picks one request at a time by round-robin,

---
 rtl/i2c_txn_arbiter_if.sv | 33 +++
 rtl/i2c_txn_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_arbiter_if.sv
// Bundle between the transaction arbiter, its requesters and the shared i2c_master.
// The slave modport is the arbiter's view. The master modport is the view of whatever drives it.
interface i2c_txn_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_op;
    logic [8*NREQ-1:0] req_din;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   cmpl;
    logic              cmpl_err;
    logic              cmpl_tmo;
    logic [7:0]        rdata;
    logic              m_newd;
    logic [6:0]        m_addr;
    logic              m_op;
    logic [7:0]        m_din;
    logic              m_busy;
    logic              m_done;
    logic              m_ack_err;
    logic [7:0]        m_dout;

    modport slave (
        input  req, req_addr, req_op, req_din, m_busy, m_done, m_ack_err, m_dout,
        output gnt, cmpl, cmpl_err, cmpl_tmo, rdata, m_newd, m_addr, m_op, m_din
    );

    modport master (
        output req, req_addr, req_op, req_din, m_busy, m_done, m_ack_err, m_dout,
        input  gnt, cmpl, cmpl_err, cmpl_tmo, rdata, m_newd, m_addr, m_op, m_din
    );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one i2c_master among NREQ requesters.
// Each grant issues exactly one transaction, which ends in done, NACK or a timeout.
module i2c_txn_arbiter #(
    parameter int NREQ        = 4,
    parameter int BUSY_WAIT   = 8,
    parameter int TIMEOUT_CYC = 16384
) (
    input  logic              clk,
    input  logic              rst_n,
    i2c_txn_arbiter_if.slave  bus
);
    localparam int TMAX = (TIMEOUT_CYC > BUSY_WAIT) ? TIMEOUT_CYC : BUSY_WAIT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [TW-1:0] BUSY_LAST = TW'(BUSY_WAIT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_BUSY = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_CMPL      = 3'd3,
        S_DRAIN     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   cmpl_q, cmpl_d;
    logic              cmpl_err_q, cmpl_err_d;
    logic              cmpl_tmo_q, cmpl_tmo_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              m_newd_q, m_newd_d;
    logic [6:0]        m_addr_q, m_addr_d;
    logic              m_op_q, m_op_d;
    logic [7:0]        m_din_q, m_din_d;

    logic              hi_found_s, lo_found_s;
    logic [PW-1:0]     hi_idx_s, lo_idx_s, win_idx_s;
    logic [NREQ-1:0]   win_oh_s;
    logic [6:0]        win_addr_s;
    logic              win_op_s;
    logic [7:0]        win_din_s;

    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
        if (t != {TW{1'b1}}) begin
            return t + TW'(1);
        end else begin
            return t;
        end
    endfunction

    // Winner: lowest set request at or above the pointer, else lowest set request overall
    always_comb begin
        hi_found_s = 1'b0;
        lo_found_s = 1'b0;
        hi_idx_s   = {PW{1'b0}};
        lo_idx_s   = {PW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i] && !hi_found_s && (PW'(i) >= ptr_q)) begin
                hi_found_s = 1'b1;
                hi_idx_s   = PW'(i);
            end else begin
                hi_found_s = hi_found_s;
            end
            if (bus.req[i] && !lo_found_s) begin
                lo_found_s = 1'b1;
                lo_idx_s   = PW'(i);
            end else begin
                lo_found_s = lo_found_s;
            end
        end
        win_idx_s = hi_found_s ? hi_idx_s : lo_idx_s;
        win_oh_s  = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
    end

    // Route the winning requester's command fields
    always_comb begin
        win_addr_s = 7'd0;
        win_op_s   = 1'b0;
        win_din_s  = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (PW'(i) == win_idx_s) begin
                win_addr_s = bus.req_addr[i*7 +: 7];
                win_op_s   = bus.req_op[i];
                win_din_s  = bus.req_din[i*8 +: 8];
            end else begin
                win_op_s   = win_op_s;
            end
        end
    end

    // Transaction FSM: next state and next register values
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        gnt_d      = gnt_q;
        cmpl_d     = {NREQ{1'b0}};
        cmpl_err_d = cmpl_err_q;
        cmpl_tmo_d = cmpl_tmo_q;
        rdata_d    = rdata_q;
        m_newd_d   = 1'b0;
        m_addr_d   = m_addr_q;
        m_op_d     = m_op_q;
        m_din_d    = m_din_q;
        case (state_q)
            S_IDLE: begin
                if (lo_found_s) begin
                    gnt_d    = win_oh_s;
                    m_addr_d = win_addr_s;
                    m_op_d   = win_op_s;
                    m_din_d  = win_din_s;
                    m_newd_d = 1'b1;
                    ptr_d    = (win_idx_s == PTR_LAST) ? {PW{1'b0}} : win_idx_s + PW'(1);
                    timer_d  = {TW{1'b0}};
                    state_d  = S_WAIT_BUSY;
                end else begin
                    gnt_d    = {NREQ{1'b0}};
                end
            end
            S_WAIT_BUSY: begin
                if (bus.m_busy) begin
                    timer_d = {TW{1'b0}};
                    state_d = S_WAIT_DONE;
                end else if (timer_q == BUSY_LAST) begin
                    cmpl_d     = gnt_q;
                    cmpl_err_d = 1'b1;
                    cmpl_tmo_d = 1'b1;
                    state_d    = S_CMPL;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            S_WAIT_DONE: begin
                // done takes priority over a timeout landing in the same cycle
                if (bus.m_done) begin
                    cmpl_d     = gnt_q;
                    cmpl_err_d = bus.m_ack_err;
                    cmpl_tmo_d = 1'b0;
                    rdata_d    = m_op_q ? bus.m_dout : rdata_q;
                    state_d    = S_CMPL;
                end else if (timer_q == TMO_LAST) begin
                    cmpl_d     = gnt_q;
                    cmpl_err_d = 1'b1;
                    cmpl_tmo_d = 1'b1;
                    state_d    = S_CMPL;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            S_CMPL: begin
                gnt_d   = {NREQ{1'b0}};
                state_d = bus.m_busy ? S_DRAIN : S_IDLE;
            end
            S_DRAIN: begin
                if (!bus.m_busy) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                gnt_d   = {NREQ{1'b0}};
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ptr_q      <= {PW{1'b0}};
            timer_q    <= {TW{1'b0}};
            gnt_q      <= {NREQ{1'b0}};
            cmpl_q     <= {NREQ{1'b0}};
            cmpl_err_q <= 1'b0;
            cmpl_tmo_q <= 1'b0;
            rdata_q    <= 8'd0;
            m_newd_q   <= 1'b0;
            m_addr_q   <= 7'd0;
            m_op_q     <= 1'b0;
            m_din_q    <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            timer_q    <= timer_d;
            gnt_q      <= gnt_d;
            cmpl_q     <= cmpl_d;
            cmpl_err_q <= cmpl_err_d;
            cmpl_tmo_q <= cmpl_tmo_d;
            rdata_q    <= rdata_d;
            m_newd_q   <= m_newd_d;
            m_addr_q   <= m_addr_d;
            m_op_q     <= m_op_d;
            m_din_q    <= m_din_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.cmpl     = cmpl_q;
    assign bus.cmpl_err = cmpl_err_q;
    assign bus.cmpl_tmo = cmpl_tmo_q;
    assign bus.rdata    = rdata_q;
    assign bus.m_newd   = m_newd_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_op     = m_op_q;
    assign bus.m_din    = m_din_q;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: a master BFM plus a transaction-level model.
// The model predicts the winner, the completion latency and the completion status for each grant.
module tb_i2c_txn_arbiter;
    localparam int N   = 4;
    localparam int BW  = 8;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    int         ptr_m   = 0;
    logic [7:0] rdata_m = 8'h00;
    logic [6:0] addr_m [N];
    logic       op_m   [N];
    logic [7:0] din_m  [N];

    i2c_txn_arbiter_if #(.NREQ(N)) bus();

    i2c_txn_arbiter #(.NREQ(N), .BUSY_WAIT(BW), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int model_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [6:0] a, input logic o, input logic [7:0] d);
        addr_m[i] = a;
        op_m[i]   = o;
        din_m[i]  = d;
        bus.req_addr[i*7 +: 7] = a;
        bus.req_op[i]          = o;
        bus.req_din[i*8 +: 8]  = d;
        bus.req[i]             = 1'b1;
    endtask

    // mode 0: ACK, 1: NACK, 2: busy never rises, 3: busy rises, done never comes.
    // b: busy-rise delay after newd, d: done delay into WAIT_DONE, e: busy tail after cmpl.
    task automatic run_txn(input int mode, input int b, input int d, input int e,
                           input logic [7:0] dout, output int w);
        int waitc, exp_off, busy_end, kd;
        logic exp_err, exp_tmo, bad;
        logic [N-1:0] exp_gnt;
        w = model_pick(bus.req, ptr_m);
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (bus.m_newd !== 1'b1 && waitc < 20);
        n_tests++;
        if (waitc != 1 || w < 0) begin
            $display("FAIL issue: newd after %0d cycles for winner %0d, required 1 cycle", waitc, w);
            n_fail++;
            w = -1;
            return;
        end
        exp_gnt = N'(1) << w;
        n_tests++;
        if (bus.gnt !== exp_gnt || bus.m_addr !== addr_m[w] || bus.m_op !== op_m[w] || bus.m_din !== din_m[w]) begin
            $display("FAIL grant: gnt=%b addr=%h op=%b din=%h, required gnt=%b addr=%h op=%b din=%h",
                     bus.gnt, bus.m_addr, bus.m_op, bus.m_din, exp_gnt, addr_m[w], op_m[w], din_m[w]);
            n_fail++;
        end
        ptr_m = (w + 1) % N;
        kd = b + 1 + d;
        case (mode)
            0, 1: begin
                exp_off = kd + 1;
                exp_err = (mode == 1);
                exp_tmo = 1'b0;
                if (op_m[w]) rdata_m = dout;
            end
            2: begin
                exp_off = BW;
                exp_err = 1'b1;
                exp_tmo = 1'b1;
            end
            default: begin
                exp_off = b + 1 + TMO;
                exp_err = 1'b1;
                exp_tmo = 1'b1;
            end
        endcase
        busy_end = (mode == 2) ? exp_off : exp_off + e;
        bad = 1'b0;
        for (int k = 0; k <= busy_end + 1; k++) begin
            if (k > 0) begin
                @(negedge clk);
                if (k == exp_off) begin
                    n_tests++;
                    if (bus.cmpl !== exp_gnt || bus.gnt !== exp_gnt || bus.m_newd !== 1'b0 ||
                        bus.cmpl_err !== exp_err || bus.cmpl_tmo !== exp_tmo || bus.rdata !== rdata_m) begin
                        $display("FAIL cmpl: cmpl=%b gnt=%b err=%b tmo=%b rdata=%h, required cmpl=%b err=%b tmo=%b rdata=%h at offset %0d",
                                 bus.cmpl, bus.gnt, bus.cmpl_err, bus.cmpl_tmo, bus.rdata,
                                 exp_gnt, exp_err, exp_tmo, rdata_m, exp_off);
                        n_fail++;
                    end
                    bus.req[w] = 1'b0;
                end else if (k < exp_off) begin
                    if (bus.cmpl !== '0 || bus.m_newd !== 1'b0 || bus.gnt !== exp_gnt ||
                        bus.m_addr !== addr_m[w] || bus.m_din !== din_m[w]) bad = 1'b1;
                end else begin
                    if (bus.cmpl !== '0 || bus.m_newd !== 1'b0 || bus.gnt !== '0) bad = 1'b1;
                end
            end
            bus.m_busy    = (mode != 2) && (k >= b) && (k < busy_end);
            bus.m_done    = (mode <= 1) && (k == kd);
            bus.m_ack_err = (mode == 1) && (k == kd);
            bus.m_dout    = (k == kd) ? dout : 8'($urandom);
        end
        n_tests++;
        if (bad) begin
            $display("FAIL window: unexpected gnt/cmpl/newd activity around grant to %0d (mode %0d), required quiet", w, mode);
            n_fail++;
        end
    endtask

    task automatic check_winner(input string name, input int w, input int exp_w);
        n_tests++;
        if (w != exp_w) begin
            $display("FAIL %s: winner %0d, required %0d", name, w, exp_w);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        bool_ok: begin end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({bus.gnt, bus.cmpl, bus.cmpl_err, bus.cmpl_tmo, bus.rdata, bus.m_newd,
             bus.m_addr, bus.m_op, bus.m_din} !== '0) begin
            $display("FAIL reset_outputs: gnt=%b cmpl=%b newd=%b rdata=%h, required all 0",
                     bus.gnt, bus.cmpl, bus.m_newd, bus.rdata);
            n_fail++;
        end
        rst_n = 1'b1;
        n_tests++;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.m_newd !== 1'b0 || bus.gnt !== '0) begin
                $display("FAIL idle_quiet: newd=%b gnt=%b with no request, required 0", bus.m_newd, bus.gnt);
                n_fail++;
                break;
            end
        end
    endtask

    task automatic test_single_write();
        int w;
        set_req(0, 7'h50, 1'b0, 8'hA5);
        run_txn(0, 2, 5, 0, 8'h00, w);
        check_winner("single_write", w, 0);
    endtask

    task automatic test_read();
        int w;
        set_req(2, 7'h68, 1'b1, 8'h00);
        run_txn(0, 1, 7, 2, 8'h3C, w);
        check_winner("read", w, 2);
        @(negedge clk);
        n_tests++;
        if (bus.rdata !== 8'h3C) begin
            $display("FAIL read_hold: rdata=%h, required 3c", bus.rdata);
            n_fail++;
        end
    endtask

    task automatic test_round_robin();
        int w;
        int order [5] = '{0, 1, 2, 3, 0};
        set_req(3, 7'h11, 1'b0, 8'h22);
        run_txn(0, 1, 2, 0, 8'h00, w);
        check_winner("rr_prime", w, 3);
        for (int i = 0; i < N; i++) set_req(i, 7'($urandom), 1'($urandom), 8'($urandom));
        for (int t = 0; t < 5; t++) begin
            run_txn(0, 1 + t % 3, t, t % 2, 8'($urandom), w);
            check_winner("round_robin", w, order[t]);
            if (w >= 0) set_req(w, 7'($urandom), 1'($urandom), 8'($urandom));
        end
        bus.req = '0;
    endtask

    task automatic test_nack();
        int w;
        set_req(1, 7'h2A, 1'b1, 8'h00);
        set_req(2, 7'h2B, 1'b0, 8'h5A);
        run_txn(1, 2, 3, 1, 8'h99, w);
        check_winner("nack", w, 1);
        run_txn(0, 1, 1, 0, 8'h00, w);
        check_winner("after_nack", w, 2);
    endtask

    task automatic test_no_busy();
        int w;
        set_req(0, 7'h0F, 1'b1, 8'h00);
        run_txn(2, 1, 0, 0, 8'h77, w);
        check_winner("no_busy", w, 0);
    endtask

    task automatic test_stuck();
        int w;
        set_req(3, 7'h33, 1'b1, 8'h00);
        set_req(0, 7'h44, 1'b0, 8'h81);
        run_txn(3, 3, 0, 5, 8'h00, w);
        check_winner("stuck", w, 3);
        run_txn(0, 1, 2, 0, 8'h00, w);
        check_winner("after_stuck", w, 0);
        set_req(1, 7'h55, 1'b1, 8'h00);
        run_txn(0, 2, TMO - 1, 0, 8'hC3, w);
        check_winner("done_tmo_tie", w, 1);
    endtask

    task automatic test_reset_mid();
        int w;
        set_req(0, 7'h21, 1'b0, 8'h10);
        @(negedge clk);
        @(negedge clk);
        bus.m_busy = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (bus.gnt !== 4'b0001) begin
            $display("FAIL pre_reset_gnt: gnt=%b, required 0001", bus.gnt);
            n_fail++;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.gnt !== '0 || bus.cmpl !== '0 || bus.m_newd !== 1'b0) begin
            $display("FAIL reset_mid: gnt=%b cmpl=%b newd=%b, required 0", bus.gnt, bus.cmpl, bus.m_newd);
            n_fail++;
        end
        bus.m_busy = 1'b0;
        bus.req    = '0;
        set_req(1, 7'h3E, 1'b1, 8'h00);
        repeat (3) @(negedge clk);
        ptr_m   = 0;
        rdata_m = 8'h00;
        rst_n   = 1'b1;
        run_txn(0, 1, 3, 0, 8'h6D, w);
        check_winner("after_reset", w, 1);
    endtask

    task automatic test_random();
        int w, mode, r;
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && $urandom_range(0, 1) == 1)
                    set_req(i, 7'($urandom), 1'($urandom), 8'($urandom));
            end
            if (bus.req == '0) set_req(int'($urandom_range(0, N - 1)), 7'($urandom), 1'($urandom), 8'($urandom));
            r = int'($urandom_range(0, 9));
            mode = (r <= 5) ? 0 : (r <= 7) ? 1 : (r == 8) ? 2 : 3;
            run_txn(mode, int'($urandom_range(1, BW - 2)), int'($urandom_range(0, 12)),
                    int'($urandom_range(0, 3)), 8'($urandom), w);
        end
        bus.req = '0;
    endtask

    initial begin
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.req_op    = '0;
        bus.req_din   = '0;
        bus.m_busy    = 1'b0;
        bus.m_done    = 1'b0;
        bus.m_ack_err = 1'b0;
        bus.m_dout    = 8'h00;
        rst_n         = 1'b0;
        test_reset();
        test_single_write();
        test_read();
        test_round_robin();
        test_nack();
        test_no_busy();
        test_stuck();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
